multicore_mem_arbiter: RTL and testbench

MULTICORE_MEM_ARBITER -- requirements
Module: multicore_mem_arbiter

---
 rtl/multicore_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/multicore_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_multicore_mem_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicore_pkg.sv
// Shared types for the multicore memory arbiter: FSM state encoding, default sizing
// and the latched request record presented on the shared memory port.
package multicore_pkg;

    localparam int DEFAULT_N  = 2;
    localparam int DEFAULT_AW = 32;
    // picorv32 addresses are 32 bits, so the request record never needs more.
    localparam int MAX_AW     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              instr;
        logic [MAX_AW-1:0] addr;
        logic [31:0]       wdata;
        logic [3:0]        wstrb;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr wins,
// scanning upward and wrapping from N-1 back to 0.
module rr_arbiter
    import multicore_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] slot_s;

    // Scan the N slots in priority order and keep only the first hit.
    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        slot_s = '0;
        for (int i = 0; i < N; i++) begin
            slot_s = IW'((int'(ptr) + i) % N);
            if (!any && req[slot_s]) begin
                grant[slot_s] = 1'b1;
                idx           = slot_s;
                any           = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// Shares one picorv32 native memory port among N cores: round-robin grant, a single
// transaction in flight, and fully registered outputs on both sides.
module multicore_mem_arbiter
    import multicore_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int AW = DEFAULT_AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           core_valid,
    input  logic [N-1:0]           core_instr,
    input  logic [N-1:0][AW-1:0]   core_addr,
    input  logic [N-1:0][31:0]     core_wdata,
    input  logic [N-1:0][3:0]      core_wstrb,
    output logic [N-1:0]           core_ready,
    output logic [N-1:0][31:0]     core_rdata,
    output logic                   mem_valid,
    output logic                   mem_instr,
    output logic [AW-1:0]          mem_addr,
    output logic [31:0]            mem_wdata,
    output logic [3:0]             mem_wstrb,
    input  logic                   mem_ready,
    input  logic [31:0]            mem_rdata,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy
);

    localparam int            IW    = $clog2(N);
    localparam logic [N-1:0]  ONE_N = N'(1);

    arb_state_e          state_r;
    logic [IW-1:0]       rr_ptr_r;
    logic [IW-1:0]       grant_id_r;
    mem_req_t            req_r;
    logic                mem_valid_r;
    logic [N-1:0]        core_ready_r;
    logic [N-1:0][31:0]  core_rdata_r;
    logic                busy_r;

    logic [N-1:0]        win_onehot_s;
    logic [IW-1:0]       win_idx_s;
    logic                win_any_s;
    mem_req_t            win_req_s;
    logic [IW-1:0]       next_ptr_s;

    rr_arbiter #(.N(N)) u_rr_arbiter (
        .req   (core_valid),
        .ptr   (rr_ptr_r),
        .grant (win_onehot_s),
        .idx   (win_idx_s),
        .any   (win_any_s)
    );

    // Pointer moves to the slot just after the core being served.
    assign next_ptr_s = (grant_id_r == IW'(N - 1)) ? '0 : grant_id_r + IW'(1);

    // One-hot AND-OR mux of the winning core's request fields.
    always_comb begin
        win_req_s = '0;
        for (int i = 0; i < N; i++) begin
            if (win_onehot_s[i]) begin
                win_req_s.instr = core_instr[i];
                win_req_s.addr  = MAX_AW'(core_addr[i]);
                win_req_s.wdata = core_wdata[i];
                win_req_s.wstrb = core_wstrb[i];
            end else begin
                win_req_s = win_req_s;
            end
        end
    end

    // Transaction FSM: grant in IDLE, hold the request in ISSUE, pulse the core in RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            rr_ptr_r     <= '0;
            grant_id_r   <= '0;
            req_r        <= '0;
            mem_valid_r  <= 1'b0;
            core_ready_r <= '0;
            core_rdata_r <= '0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    core_ready_r <= '0;
                    if (win_any_s) begin
                        req_r       <= win_req_s;
                        grant_id_r  <= win_idx_s;
                        mem_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The granted core keeps its slot even if it drops core_valid meanwhile.
                    if (mem_ready) begin
                        mem_valid_r                <= 1'b0;
                        core_ready_r               <= ONE_N << grant_id_r;
                        core_rdata_r[grant_id_r]   <= mem_rdata;
                        rr_ptr_r                   <= next_ptr_s;
                        state_r                    <= RESP;
                    end
                end
                RESP: begin
                    core_ready_r <= '0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    mem_valid_r  <= 1'b0;
                    core_ready_r <= '0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign mem_valid  = mem_valid_r;
    assign mem_instr  = req_r.instr;
    assign mem_addr   = req_r.addr[AW-1:0];
    assign mem_wdata  = req_r.wdata;
    assign mem_wstrb  = req_r.wstrb;
    assign core_ready = core_ready_r;
    assign core_rdata = core_rdata_r;
    assign grant_id   = grant_id_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Self-checking bench for multicore_mem_arbiter with four cores: directed scenarios
// plus randomized traffic against a transaction-level round-robin reference model.
module tb_multicore_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int IW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         core_valid, core_instr, core_ready;
    logic [N-1:0][AW-1:0] core_addr;
    logic [N-1:0][31:0]   core_wdata, core_rdata;
    logic [N-1:0][3:0]    core_wstrb;
    logic                 mem_valid, mem_instr, mem_ready;
    logic [AW-1:0]        mem_addr;
    logic [31:0]          mem_wdata, mem_rdata;
    logic [3:0]           mem_wstrb;
    logic [IW-1:0]        grant_id;
    logic                 busy;

    int          tests = 0;
    int          fails = 0;
    int          model_ptr = 0;
    logic [31:0] shadow [N];

    always #5 clk = ~clk;

    multicore_mem_arbiter #(.N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .core_valid(core_valid), .core_instr(core_instr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wstrb(core_wstrb),
        .core_ready(core_ready), .core_rdata(core_rdata),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    // Round-robin rule: first requester at or after p, wrapping; -1 if none.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_valid = '0; core_instr = '0; core_addr = '0;
        core_wdata = '0; core_wstrb = '0;
        mem_ready  = 1'b0; mem_rdata = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        model_ptr = 0;
        for (int i = 0; i < N; i++) shadow[i] = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        core_valid = '1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        reset = 1'b1;
        tick(); tick();
        tests++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || core_ready !== '0 || grant_id !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: mem_valid=%b busy=%b core_ready=%b grant_id=%0d, expected all 0",
                     mem_valid, busy, core_ready, grant_id);
        end
        tests++;
        if (mem_addr !== '0 || mem_wdata !== '0 || mem_wstrb !== 4'h0 || mem_instr !== 1'b0 || core_rdata !== '0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h wstrb=%h instr=%b rdata=%h, expected all 0",
                     mem_addr, mem_wdata, mem_wstrb, mem_instr, core_rdata);
        end
        reset = 1'b0;
        clear_inputs();
        model_ptr = 0;
        for (int i = 0; i < N; i++) shadow[i] = '0;
    endtask

    task automatic test_single_read();
        core_valid = 4'b0001; core_addr[0] = 32'h10; core_instr[0] = 1'b1; core_wstrb[0] = 4'h0;
        tick();
        tests++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h10 || mem_wstrb !== 4'h0 || mem_instr !== 1'b1
            || grant_id !== 2'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_issue: mv=%b addr=%h wstrb=%h instr=%b gid=%0d busy=%b, expected 1/10/0/1/0/1",
                     mem_valid, mem_addr, mem_wstrb, mem_instr, grant_id, busy);
        end
        tick();
        tests++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h10 || core_ready !== '0) begin
            fails++;
            $display("FAIL single_hold: mv=%b addr=%h ready=%b, expected 1/10/0", mem_valid, mem_addr, core_ready);
        end
        mem_ready = 1'b1; mem_rdata = 32'h0011_0113;
        tick();
        tests++;
        if (core_ready !== 4'b0001 || core_rdata[0] !== 32'h0011_0113 || mem_valid !== 1'b0 || core_rdata[1] !== 32'h0) begin
            fails++;
            $display("FAIL single_resp: ready=%b rdata0=%h rdata1=%h mv=%b, expected 0001/00110113/0/0",
                     core_ready, core_rdata[0], core_rdata[1], mem_valid);
        end
        mem_ready = 1'b0; core_valid = '0;
        tick();
        tests++;
        if (core_ready !== '0 || busy !== 1'b0 || mem_valid !== 1'b0 || core_rdata[0] !== 32'h0011_0113) begin
            fails++;
            $display("FAIL single_done: ready=%b busy=%b mv=%b rdata0=%h, expected 0/0/0/00110113",
                     core_ready, busy, mem_valid, core_rdata[0]);
        end
    endtask

    task automatic test_write();
        logic [31:0] rd;
        reset_dut();
        core_valid = 4'b0010; core_addr[1] = 32'h3FC; core_wdata[1] = 32'hDEAD_BEEF; core_wstrb[1] = 4'b0011;
        tick();
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h3FC || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'b0011
                || grant_id !== 2'd1 || core_ready !== '0) begin
                fails++;
                $display("FAIL write_stable[%0d]: mv=%b addr=%h wdata=%h wstrb=%b gid=%0d, expected 1/3fc/deadbeef/0011/1",
                         c, mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_id);
            end
            core_addr[1] = $urandom; core_wdata[1] = $urandom; core_wstrb[1] = 4'($urandom);
            core_valid[0] = 1'b1; core_addr[0] = 32'h44;
            if (c < 3) tick();
        end
        rd = $urandom;
        mem_ready = 1'b1; mem_rdata = rd;
        tick();
        tests++;
        if (core_ready !== 4'b0010 || core_rdata[1] !== rd || core_rdata[0] !== 32'h0) begin
            fails++;
            $display("FAIL write_resp: ready=%b rdata1=%h rdata0=%h, expected 0010/%h/0", core_ready, core_rdata[1], core_rdata[0], rd);
        end
        mem_ready = 1'b0; core_valid[1] = 1'b0;
        tick();
        tests++;
        if (mem_valid !== 1'b0 || core_ready !== '0) begin
            fails++;
            $display("FAIL write_no_regrant_in_resp: mv=%b ready=%b, expected 0/0", mem_valid, core_ready);
        end
        tick();
        tests++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd0 || mem_addr !== 32'h44) begin
            fails++;
            $display("FAIL write_next_grant: mv=%b gid=%0d addr=%h, expected 1/0/44", mem_valid, grant_id, mem_addr);
        end
    endtask

    task automatic test_contention();
        reset_dut();
        core_valid = 4'b0011; core_addr[0] = 32'hA0; core_addr[1] = 32'hB0;
        tick();
        tests++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd0 || mem_addr !== 32'hA0) begin
            fails++;
            $display("FAIL contention_first: mv=%b gid=%0d addr=%h, expected 1/0/a0", mem_valid, grant_id, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h1111_0000;
        tick();
        tests++;
        if (core_ready !== 4'b0001) begin
            fails++;
            $display("FAIL contention_ready0: ready=%b, expected 0001", core_ready);
        end
        mem_ready = 1'b0; core_valid[0] = 1'b0;
        tick();
        tick();
        tests++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd1 || mem_addr !== 32'hB0) begin
            fails++;
            $display("FAIL contention_second: mv=%b gid=%0d addr=%h, expected 1/1/b0", mem_valid, grant_id, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h2222_0000;
        tick();
        tests++;
        if (core_ready !== 4'b0010 || core_rdata[1] !== 32'h2222_0000 || core_rdata[0] !== 32'h1111_0000) begin
            fails++;
            $display("FAIL contention_ready1: ready=%b rdata1=%h rdata0=%h, expected 0010/22220000/11110000",
                     core_ready, core_rdata[1], core_rdata[0]);
        end
        mem_ready = 1'b0; core_valid = '0;
        tick();
        core_valid = '1;
        tick();
        tests++;
        if (grant_id !== 2'd2) begin
            fails++;
            $display("FAIL contention_ptr: gid=%0d, expected 2", grant_id);
        end
    endtask

    task automatic test_fairness();
        int  grants  = 0;
        int  core1_at = 0;
        bit  prev_mv = 1'b0;
        bit  done    = 1'b0;
        reset_dut();
        core_valid = 4'b0011; core_addr[0] = 32'h100; core_addr[1] = 32'h200;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ready = mem_valid;
            tick();
            if (mem_valid && !prev_mv) begin
                grants++;
                if (grant_id == 2'd1) core1_at = grants;
            end
            prev_mv = mem_valid;
            if (core_ready[1]) begin
                core_valid[1] = 1'b0;
                done = 1'b1;
            end
        end
        tests++;
        if (!done || core1_at == 0 || core1_at > 2) begin
            fails++;
            $display("FAIL fairness: core1 served=%b at grant %0d, expected served within 2 grants", done, core1_at);
        end
    endtask

    task automatic test_drop_valid();
        reset_dut();
        core_valid = 4'b0100; core_addr[2] = 32'hC0;
        tick();
        core_valid = '0;
        tick(); tick();
        tests++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd2 || mem_addr !== 32'hC0) begin
            fails++;
            $display("FAIL drop_hold: mv=%b gid=%0d addr=%h, expected 1/2/c0", mem_valid, grant_id, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 32'h5A5A_A5A5;
        tick();
        tests++;
        if (core_ready !== 4'b0100 || core_rdata[2] !== 32'h5A5A_A5A5) begin
            fails++;
            $display("FAIL drop_resp: ready=%b rdata2=%h, expected 0100/5a5aa5a5", core_ready, core_rdata[2]);
        end
        mem_ready = 1'b0;
        tick();
        tests++;
        if (core_ready !== '0 || busy !== 1'b0 || mem_valid !== 1'b0) begin
            fails++;
            $display("FAIL drop_done: ready=%b busy=%b mv=%b, expected 0/0/0", core_ready, busy, mem_valid);
        end
    endtask

    task automatic test_reset_mid_issue();
        reset_dut();
        core_valid = 4'b0010;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; core_valid = '0;
        tick();
        core_valid = 4'b1000;
        tick();
        tests++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd3) begin
            fails++;
            $display("FAIL rst_pre_issue: mv=%b gid=%0d, expected 1/3", mem_valid, grant_id);
        end
        reset = 1'b1; core_valid = '0;
        tick();
        reset = 1'b0;
        tests++;
        if (mem_valid !== 1'b0 || busy !== 1'b0 || core_ready !== '0) begin
            fails++;
            $display("FAIL rst_mid_issue: mv=%b busy=%b ready=%b, expected 0/0/0", mem_valid, busy, core_ready);
        end
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        tests++;
        if (core_ready !== '0 || mem_valid !== 1'b0 || busy !== 1'b0 || core_rdata[3] !== 32'h0) begin
            fails++;
            $display("FAIL rst_late_ready: ready=%b mv=%b busy=%b rdata3=%h, expected 0/0/0/0",
                     core_ready, mem_valid, busy, core_rdata[3]);
        end
        mem_ready = 1'b0; core_valid = '1;
        tick();
        tests++;
        if (mem_valid !== 1'b1 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL rst_ptr_cleared: mv=%b gid=%0d, expected 1/0", mem_valid, grant_id);
        end
    endtask

    task automatic test_random(input int cycles, input bit saturate);
        bit            granted = 1'b0;
        bit            responding = 1'b0;
        bit            bad;
        int            w = 0;
        int            pick;
        int            order[$];
        logic          exp_mv, exp_busy, exp_instr;
        logic [N-1:0]  exp_cr;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_wdata;
        logic [3:0]    exp_wstrb;
        exp_instr = 1'b0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
        for (int c = 0; c < cycles; c++) begin
            mem_ready = saturate ? mem_valid : ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            exp_cr = '0;
            if (responding) begin
                responding = 1'b0; exp_mv = 1'b0; exp_busy = 1'b0;
            end else if (granted) begin
                exp_busy = 1'b1;
                if (mem_ready) begin
                    exp_mv = 1'b0; exp_cr[w] = 1'b1; shadow[w] = mem_rdata;
                    model_ptr = (w + 1) % N; granted = 1'b0; responding = 1'b1;
                end else begin
                    exp_mv = 1'b1;
                end
            end else begin
                pick = rr_pick(core_valid, model_ptr);
                if (pick >= 0) begin
                    w = pick; granted = 1'b1; exp_mv = 1'b1; exp_busy = 1'b1;
                    exp_instr = core_instr[w]; exp_addr = core_addr[w];
                    exp_wdata = core_wdata[w]; exp_wstrb = core_wstrb[w];
                    order.push_back(w);
                end else begin
                    exp_mv = 1'b0; exp_busy = 1'b0;
                end
            end
            tick();
            tests++;
            if (mem_valid !== exp_mv || busy !== exp_busy || core_ready !== exp_cr) begin
                fails++;
                $display("FAIL rand_ctrl@%0d: mv=%b busy=%b ready=%b, expected %b/%b/%b",
                         c, mem_valid, busy, core_ready, exp_mv, exp_busy, exp_cr);
            end
            if (exp_mv) begin
                tests++;
                if (grant_id !== IW'(w) || mem_addr !== exp_addr || mem_wdata !== exp_wdata
                    || mem_wstrb !== exp_wstrb || mem_instr !== exp_instr) begin
                    fails++;
                    $display("FAIL rand_fields@%0d: gid=%0d addr=%h wdata=%h wstrb=%h instr=%b, expected %0d/%h/%h/%h/%b",
                             c, grant_id, mem_addr, mem_wdata, mem_wstrb, mem_instr, w, exp_addr, exp_wdata, exp_wstrb, exp_instr);
                end
            end
            bad = 1'b0;
            for (int i = 0; i < N; i++) if (core_rdata[i] !== shadow[i]) bad = 1'b1;
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL rand_rdata@%0d: rdata=%h, expected %h %h %h %h",
                         c, core_rdata, shadow[3], shadow[2], shadow[1], shadow[0]);
            end
            for (int i = 0; i < N; i++) begin
                if (core_ready[i]) begin
                    core_valid[i] = 1'b0;
                end else if (!core_valid[i] && (saturate || $urandom_range(0, 3) == 0)) begin
                    core_valid[i] = 1'b1;
                    core_instr[i] = 1'($urandom_range(0, 1));
                    core_addr[i]  = $urandom;
                    core_wdata[i] = $urandom;
                    core_wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                end
            end
        end
        if (saturate) begin
            bad = (order.size() < N);
            for (int k = 0; k < order.size(); k++) if (order[k] != k % N) bad = 1'b1;
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL saturate_order: %0d grants, order %p, expected 0,1,2,3 repeating", order.size(), order);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_fairness();
        test_drop_valid();
        test_reset_mid_issue();
        reset_dut();
        test_random(600, 1'b0);
        reset_dut();
        test_random(40, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
